mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between instruction fetch (IF) and the MEM stage. The MEM stage drives it from the EX/MEM pipeline register outputs: read/write strobes, ALU result as address, and store data. The block sequences each access with a req/ack handshake to memory, stalls the losing or waiting requester, and returns read data. It sits between the EX/MEM buffer, the fetch unit, and the memory interface. Global pipeline freeze is decided by the hazard unit from if_stall and mem_stall.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
TIMEOUT, 255, max cycles waiting for mem_ack before aborting (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ex_mem_read  in  1  load pending in MEM stage
ex_mem_write  in  1  store pending in MEM stage
ex_mem_addr  in  ADDR_W  load/store address (ALU result)
ex_mem_wdata  in  DATA_W  store data
mem_stall  out  1  MEM stage must hold
load_data  out  DATA_W  captured load data
load_valid  out  1  load_data valid this cycle
if_req  in  1  fetch request
if_addr  in  ADDR_W  fetch address (PC)
if_stall  out  1  fetch must hold
if_data  out  DATA_W  fetched instruction
if_valid  out  1  if_data valid this cycle
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_ack  in  1  access complete, rdata valid for reads
bus_err  out  1  sticky: timeout or illegal read+write occurred

Behaviour:
- Reset (sync, high): state=IDLE, last_grant=IF, timeout counter=0. All outputs 0 except the stalls, which follow their combinational equations. Reset mid-access drops mem_req at the next edge and discards the access.
- States: IDLE, MEM_BUSY, MEM_DONE, IF_BUSY, IF_DONE.
- mem_pend = ex_mem_read | ex_mem_write.
- IDLE arbitration:
  - Only mem_pend: go to MEM_BUSY.
  - Only if_req: go to IF_BUSY.
  - Both: MEM wins unless last_grant=MEM, in which case IF wins (alternating fairness).
  - Neither: stay in IDLE.
  - Address, write data and we are registered on the grant edge and held stable through BUSY.
- MEM_BUSY / IF_BUSY:
  - mem_req=1. mem_we=ex_mem_write in MEM_BUSY, 0 in IF_BUSY.
  - On mem_ack: capture mem_rdata into the data register and go to the matching DONE state.
  - Counter increments each cycle without ack. Reaching TIMEOUT: deassert req, set bus_err, data register=0, go to DONE.
- MEM_DONE: load_valid=ex_mem_read held from grant; load_data=register; last_grant=MEM; go to IDLE.
- IF_DONE: if_valid=1; if_data=register; last_grant=IF; go to IDLE.
- DONE states never arbitrate, so the requester advances at the end of DONE before being re-sampled.
- Stall equations:
  - mem_stall = mem_pend & (state != MEM_DONE).
  - if_stall = if_req & (state != IF_DONE).
- Latency: zero-wait memory gives a 3-cycle access (grant, busy+ack, done), i.e. 2 stall cycles. Each extra wait cycle adds 1.
- ex_mem_read & ex_mem_write together is illegal: performed as a write, load_valid=0, bus_err set.
- Requests withdrawn during BUSY: access still completes; result is discarded in DONE (valid still pulses).
- bus_err is cleared only by reset.

Decomposition:
- Shared package: state enum (5 states, 3-bit encoding), grant enum {GNT_IF, GNT_MEM}, ADDR_W/DATA_W defaults.
- One sub-module: mem_timeout_ctr (8-bit counter, clear/enable inputs, expired output compared to TIMEOUT).

Test Plan:
- Zero-wait load: ex_mem_read=1, addr=0x0010, memory returns 0xBEEF with immediate ack → mem_stall high 2 cycles; load_valid=1 with load_data=0xBEEF in cycle 3; mem_we=0.
- Store with 3 wait cycles: ex_mem_write=1, addr=0x0020, wdata=0x1234 → mem_req held 4 cycles with stable addr/wdata; mem_we=1; mem_stall drops in MEM_DONE; load_valid=0.
- Contention: if_req and ex_mem_read asserted continuously, last_grant=IF → grant order MEM, IF, MEM, IF; neither requester waits more than one foreign access.
- Timeout: TIMEOUT=4, ex_mem_read, no ack → mem_req deasserts after 4 busy cycles; bus_err=1; load_data=0x0000; bus_err stays 1 until reset.
- Illegal strobe: read=write=1, addr=0x0030 → write issued; load_valid stays 0; bus_err=1.
- Reset mid-access: reset asserted in IF_BUSY → next cycle state=IDLE, mem_req=0, if_valid=0, bus_err=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// Holds the state and grant encodings and default bus widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_BUSY = 3'd1,
        ST_MEM_DONE = 3'd2,
        ST_IF_BUSY  = 3'd3,
        ST_IF_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts busy cycles without ack; expired flags the TIMEOUT-th unacked cycle.
// Combinational expired output, no handshake; clear has priority over enable.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // expired marks the cycle that would make TIMEOUT unacked cycles.
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM onto one memory port. Zero-wait access takes 3 cycles.
// Losing or waiting requesters are held by if_stall/mem_stall until their DONE cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_wdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    state_t            state, state_nxt;
    grant_t            last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;
    logic              rd_q;
    logic              bus_err_q;
    logic              mem_pend;
    logic              busy;
    logic              expired;
    logic              grant_mem;
    logic              grant_if;

    assign mem_pend = ex_mem_read | ex_mem_write;
    assign busy     = (state == ST_MEM_BUSY) || (state == ST_IF_BUSY);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy && !mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        case (state)
            ST_IDLE: begin
                // MEM wins a tie unless it took the previous access.
                if (mem_pend && (!if_req || last_grant == GNT_IF)) begin
                    grant_mem = 1'b1;
                    state_nxt = ST_MEM_BUSY;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = ST_IF_BUSY;
                end
            end
            ST_MEM_BUSY: if (mem_ack || expired) state_nxt = ST_MEM_DONE;
            ST_IF_BUSY:  if (mem_ack || expired) state_nxt = ST_IF_DONE;
            ST_MEM_DONE: state_nxt = ST_IDLE;
            ST_IF_DONE:  state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= GNT_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_mem) begin
                addr_q  <= ex_mem_addr;
                wdata_q <= ex_mem_wdata;
                we_q    <= ex_mem_write;
                // Simultaneous read+write is executed as a write only.
                rd_q    <= ex_mem_read & ~ex_mem_write;
                if (ex_mem_read && ex_mem_write) bus_err_q <= 1'b1;
            end
            if (grant_if) begin
                addr_q <= if_addr;
                we_q   <= 1'b0;
                rd_q   <= 1'b0;
            end
            if (busy) begin
                if (mem_ack) begin
                    data_q <= mem_rdata;
                end else if (expired) begin
                    data_q    <= '0;
                    bus_err_q <= 1'b1;
                end
            end
            if (state == ST_MEM_DONE) last_grant <= GNT_MEM;
            if (state == ST_IF_DONE)  last_grant <= GNT_IF;
        end
    end

    assign mem_req    = busy;
    assign mem_we     = (state == ST_MEM_BUSY) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign load_valid = (state == ST_MEM_DONE) && rd_q;
    assign load_data  = (state == ST_MEM_DONE) ? data_q : '0;
    assign if_valid   = (state == ST_IF_DONE);
    assign if_data    = (state == ST_IF_DONE) ? data_q : '0;
    assign mem_stall  = mem_pend && (state != ST_MEM_DONE);
    assign if_stall   = if_req && (state != ST_IF_DONE);
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple wait-state memory responder.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [15:0] ex_mem_addr;
    logic [15:0] ex_mem_wdata;
    logic        mem_stall;
    logic [15:0] load_data;
    logic        load_valid;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_stall;
    logic [15:0] if_data;
    logic        if_valid;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  req_cyc;
    logic [7:0]  ack_delay;
    logic        ack_en;
    logic [15:0] rdata_val;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_wdata (ex_mem_wdata),
        .mem_stall    (mem_stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_stall     (if_stall),
        .if_data      (if_data),
        .if_valid     (if_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after ack_delay wait cycles of an outstanding request.
    always @(posedge clk) begin
        if (!mem_req || mem_ack) req_cyc <= 8'd0;
        else                     req_cyc <= req_cyc + 8'd1;
    end
    assign mem_ack   = mem_req & ack_en & (req_cyc == ack_delay);
    assign mem_rdata = rdata_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ex_mem_read = 0; ex_mem_write = 0; ex_mem_addr = 0; ex_mem_wdata = 0;
        if_req = 0; if_addr = 0; ack_en = 1'b1; ack_delay = 8'd0; rdata_val = 16'h0000;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_mem_stall", mem_stall, 0);
        reset = 1'b0;

        // Zero-wait load
        rdata_val = 16'hBEEF;
        ex_mem_read = 1; ex_mem_addr = 16'h0010;
        #1 check("ld_stall_c1", mem_stall, 1);
        tick();
        check("ld_stall_c2", mem_stall, 1);
        check("ld_req", mem_req, 1);
        check("ld_we", mem_we, 0);
        check("ld_addr", mem_addr, 16'h0010);
        tick();
        check("ld_stall_c3", mem_stall, 0);
        check("ld_valid", load_valid, 1);
        check("ld_data", load_data, 16'hBEEF);
        ex_mem_read = 0;
        tick();
        check("ld_valid_after", load_valid, 0);

        // Store with 3 wait cycles; inputs change after grant to prove registering
        ack_delay = 8'd3;
        ex_mem_write = 1; ex_mem_addr = 16'h0020; ex_mem_wdata = 16'h1234;
        tick();
        ex_mem_addr = 16'hFFFF; ex_mem_wdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            check("st_req", mem_req, 1);
            check("st_we", mem_we, 1);
            check("st_addr", mem_addr, 16'h0020);
            check("st_wdata", mem_wdata, 16'h1234);
            check("st_stall", mem_stall, 1);
            tick();
        end
        check("st_req_done", mem_req, 0);
        check("st_stall_done", mem_stall, 0);
        check("st_load_valid", load_valid, 0);
        check("st_bus_err", bus_err, 0);
        ex_mem_write = 0;
        tick();

        // Contention from a fresh reset (last_grant=IF): expect MEM, IF, MEM, IF
        reset = 1; tick(); reset = 0;
        ack_delay = 8'd0; rdata_val = 16'hA5A5;
        ex_mem_read = 1; ex_mem_addr = 16'h0040; if_req = 1; if_addr = 16'h0100;
        #1;
        for (int c = 0; c < 12; c++) begin
            int p;
            p = c % 6;
            check("ct_req", mem_req, (p == 1 || p == 4) ? 1 : 0);
            if (p == 1) check("ct_addr_mem", mem_addr, 16'h0040);
            if (p == 4) check("ct_addr_if", mem_addr, 16'h0100);
            check("ct_load_valid", load_valid, (p == 2) ? 1 : 0);
            check("ct_if_valid", if_valid, (p == 5) ? 1 : 0);
            check("ct_mem_stall", mem_stall, (p == 2) ? 0 : 1);
            check("ct_if_stall", if_stall, (p == 5) ? 0 : 1);
            if (p == 2) check("ct_load_data", load_data, 16'hA5A5);
            if (p == 5) check("ct_if_data", if_data, 16'hA5A5);
            tick();
        end
        ex_mem_read = 0; if_req = 0;
        tick();

        // Timeout: no ack, TIMEOUT=4
        ack_en = 0;
        ex_mem_read = 1; ex_mem_addr = 16'h0050;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_req", mem_req, 1);
            check("to_bus_err_pre", bus_err, 0);
            tick();
        end
        check("to_req_drop", mem_req, 0);
        check("to_bus_err", bus_err, 1);
        check("to_load_data", load_data, 16'h0000);
        check("to_load_valid", load_valid, 1);
        ex_mem_read = 0;
        tick(); tick(); tick();
        check("to_bus_err_sticky", bus_err, 1);
        check("to_req_idle", mem_req, 0);

        // Illegal read+write
        reset = 1; tick(); reset = 0;
        check("il_bus_err_rst", bus_err, 0);
        ack_en = 1; ack_delay = 8'd0;
        ex_mem_read = 1; ex_mem_write = 1; ex_mem_addr = 16'h0030; ex_mem_wdata = 16'h5555;
        tick();
        check("il_req", mem_req, 1);
        check("il_we", mem_we, 1);
        check("il_addr", mem_addr, 16'h0030);
        check("il_wdata", mem_wdata, 16'h5555);
        tick();
        check("il_load_valid", load_valid, 0);
        check("il_bus_err", bus_err, 1);
        ex_mem_read = 0; ex_mem_write = 0;
        tick();

        // Reset in the middle of an IF access
        ack_en = 0;
        if_req = 1; if_addr = 16'h0200;
        tick();
        check("rm_req_busy", mem_req, 1);
        check("rm_we_busy", mem_we, 0);
        check("rm_addr_busy", mem_addr, 16'h0200);
        reset = 1;
        tick();
        check("rm_req", mem_req, 0);
        check("rm_if_valid", if_valid, 0);
        check("rm_bus_err", bus_err, 0);
        check("rm_if_stall", if_stall, 1);
        reset = 0; if_req = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
